// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchronizer, mid-bit sampling FSM
// with configurable data width, parity and stop bits, and a valid/ready
// holding register that reports parity, framing and overrun conditions.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic rx_meta;
  logic rxs;
  logic rxs_prev;
  logic fall;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_err_acc, par_err_nxt;
  logic                 frm_err_acc, frm_err_nxt;
  logic                 frame_done;

  // Bring the asynchronous line into the clock domain and keep the previous sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;
  assign busy = (state != S_IDLE);

  // Frame-tracking state, counters and the partially assembled word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      par_err_acc <= 1'b0;
      frm_err_acc <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      stop_idx    <= stop_idx_nxt;
      shreg       <= shreg_nxt;
      par_err_acc <= par_err_nxt;
      frm_err_acc <= frm_err_nxt;
    end
  end

  // Next-state logic: half-bit wait to the start mid-point, then full-bit steps through data, parity and stop
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    par_err_nxt  = par_err_acc;
    frm_err_nxt  = frm_err_acc;
    frame_done   = 1'b0;

    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt    = S_DATA;
            cnt_nxt      = '0;
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
            par_err_nxt  = 1'b0;
            frm_err_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) begin
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_STOP;
          if (PARITY == 1) begin
            par_err_nxt = ~(^shreg ^ rxs);
          end else begin
            par_err_nxt = ^shreg ^ rxs;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt     = '0;
          frm_err_nxt = frm_err_acc | ~rxs;
          if (stop_idx == STOP_LAST) begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            stop_idx_nxt = stop_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding register: load a finished frame if the slot is free or being emptied, otherwise drop it and flag overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!valid || ready) begin
          data       <= shreg_nxt;
          parity_err <= par_err_acc;
          frame_err  <= frm_err_nxt;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 8E1, 7N2) share a
// clock and reset; stimulus pushes expected words, monitors pop on handshake.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;

  logic       rx0, rx1, rx2;
  logic       ready0, ready1, ready2;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic       valid0, valid1, valid2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       ovr0, ovr1, ovr2;
  logic       busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt0 = 0;
  int ovr_cnt1 = 0;
  int ovr_cnt2 = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .rx(rx2), .data(data2), .valid(valid2), .ready(ready2),
    .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2), .busy(busy2)
  );

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int dut, input logic v);
    case (dut)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic push_exp(input int dut, input logic [7:0] d, input logic pe, input logic fe);
    case (dut)
      0:       q0.push_back({d, pe, fe});
      1:       q1.push_back({d, pe, fe});
      default: q2.push_back({d, pe, fe});
    endcase
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input int dut, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] exp;
    int         depth;
    case (dut)
      0:       depth = q0.size();
      1:       depth = q1.size();
      default: depth = q2.size();
    endcase
    if (depth == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL word_dut%0d: got data=0x%0h perr=%0b ferr=%0b, expected no word", dut, d, pe, fe);
    end else begin
      case (dut)
        0:       exp = q0.pop_front();
        1:       exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      compare($sformatf("word_dut%0d {data,perr,ferr}", dut), {22'd0, d, pe, fe}, {22'd0, exp});
    end
  endtask

  // Drive one frame LSB-first; parity bit and stop level are explicit so errors can be injected
  task automatic apply_stimulus(input int dut, input logic [7:0] word, input int nbits,
                                input bit use_par, input logic par_bit,
                                input logic stop_val, input int nstop);
    set_line(dut, 1'b0);
    wait_cycles(CPB);
    for (int i = 0; i < nbits; i++) begin
      set_line(dut, word[i]);
      wait_cycles(CPB);
    end
    if (use_par) begin
      set_line(dut, par_bit);
      wait_cycles(CPB);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(dut, stop_val);
      wait_cycles(CPB);
    end
    set_line(dut, 1'b1);
  endtask

  // Monitor for the 8N1 receiver: check every accepted word against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && valid0 && ready0) check_output(0, data0, perr0, ferr0);
  end

  // Monitor for the even-parity receiver
  always @(negedge clk) begin
    if (rst === 1'b1 && valid1 && ready1) check_output(1, data1, perr1, ferr1);
  end

  // Monitor for the 7-bit two-stop receiver
  always @(negedge clk) begin
    if (rst === 1'b1 && valid2 && ready2) check_output(2, {1'b0, data2}, perr2, ferr2);
  end

  // Count overrun cycles so a stuck or repeated pulse shows up in the totals
  always @(negedge clk) begin
    if (ovr0 === 1'b1) ovr_cnt0++;
    if (ovr1 === 1'b1) ovr_cnt1++;
    if (ovr2 === 1'b1) ovr_cnt2++;
  end

  // Hard stop if the run never reaches its summary
  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst    = 1'b0;
    rx0    = 1'b1;
    rx1    = 1'b1;
    rx2    = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;
    ready2 = 1'b1;
    wait_cycles(3);
    compare("reset_outputs_dut0", {19'd0, data0, valid0, perr0, ferr0, ovr0, busy0}, 32'd0);
    compare("reset_outputs_dut1", {19'd0, data1, valid1, perr1, ferr1, ovr1, busy1}, 32'd0);
    rst = 1'b1;
    wait_cycles(5);

    // 8N1 basic frame, busy checked mid-frame
    push_exp(0, 8'hA5, 1'b0, 1'b0);
    fork
      apply_stimulus(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
      begin
        wait_cycles(CPB * 4);
        compare("busy_mid_frame", {31'd0, busy0}, 32'd1);
      end
    join
    wait_cycles(4);
    compare("busy_idle_after", {31'd0, busy0}, 32'd0);

    // Stop bit forced low, then a clean frame
    push_exp(0, 8'h3C, 1'b0, 1'b1);
    apply_stimulus(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
    wait_cycles(6);
    push_exp(0, 8'h11, 1'b0, 1'b0);
    apply_stimulus(0, 8'h11, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_cycles(6);

    // Break: line held low for twelve bit times
    push_exp(0, 8'h00, 1'b0, 1'b1);
    set_line(0, 1'b0);
    wait_cycles(CPB * 12);
    set_line(0, 1'b1);
    wait_cycles(CPB * 2);
    compare("busy_after_break", {31'd0, busy0}, 32'd0);

    // Overrun: consumer stalled over two back-to-back frames
    ready0 = 1'b0;
    push_exp(0, 8'h12, 1'b0, 1'b0);
    apply_stimulus(0, 8'h12, 8, 1'b0, 1'b0, 1'b1, 1);
    apply_stimulus(0, 8'h34, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_cycles(4);
    compare("hold_data", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'h12});
    ready0 = 1'b1;
    wait_cycles(1);
    compare("valid_drop", {31'd0, valid0}, 32'd0);
    wait_cycles(4);

    // Short glitch while idle, then a real frame
    set_line(0, 1'b0);
    wait_cycles(4);
    compare("busy_on_glitch", {31'd0, busy0}, 32'd1);
    wait_cycles(1);
    set_line(0, 1'b1);
    wait_cycles(20);
    compare("busy_after_glitch", {31'd0, busy0}, 32'd0);
    push_exp(0, 8'h5A, 1'b0, 1'b0);
    apply_stimulus(0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_cycles(6);

    // Even parity: correct parity bit, then wrong parity bit
    push_exp(1, 8'h07, 1'b0, 1'b0);
    apply_stimulus(1, 8'h07, 8, 1'b1, 1'b1, 1'b1, 1);
    wait_cycles(6);
    push_exp(1, 8'h07, 1'b1, 1'b0);
    apply_stimulus(1, 8'h07, 8, 1'b1, 1'b0, 1'b1, 1);
    wait_cycles(6);

    // 7N2: a complete frame, a frame cut by reset, then a resend
    push_exp(2, 8'h55, 1'b0, 1'b0);
    apply_stimulus(2, 8'h55, 7, 1'b0, 1'b0, 1'b1, 2);
    wait_cycles(6);
    set_line(2, 1'b0);
    wait_cycles(CPB);
    set_line(2, 1'b1);
    wait_cycles(CPB * 3);
    compare("busy7_mid", {31'd0, busy2}, 32'd1);
    rst = 1'b0;
    wait_cycles(2);
    compare("reset_mid_frame_dut2", {20'd0, data2, valid2, perr2, ferr2, ovr2, busy2}, 32'd0);
    rst = 1'b1;
    wait_cycles(CPB * 4);
    compare("no_output_after_abort", {31'd0, valid2}, 32'd0);
    push_exp(2, 8'h7F, 1'b0, 1'b0);
    apply_stimulus(2, 8'h7F, 7, 1'b0, 1'b0, 1'b1, 2);
    wait_cycles(6);

    // Drain: every expected word must have been delivered
    for (int i = 0; i < 200 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
      wait_cycles(1);
    end
    compare("words_outstanding", q0.size() + q1.size() + q2.size(), 32'd0);
    compare("overrun_cycles_dut0", ovr_cnt0, 32'd1);
    compare("overrun_cycles_dut1", ovr_cnt1, 32'd0);
    compare("overrun_cycles_dut2", ovr_cnt2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1/115200 receiver. It adds configurable bit period, data width, parity and stop bits. Each frame is sampled at mid-bit, and the received word is delivered through a valid/ready holding register with parity, framing and overrun reporting. It sits between the board RX pin and any byte consumer (FIFO, command parser).

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx  input  1  serial line, asynchronous to clk, idle high
data  output  DATA_BITS  received word, LSB = first data bit on the line
valid  output  1  holding register contains an undelivered word
ready  input  1  consumer accepts the word when valid && ready
parity_err  output  1  parity mismatch for the word in data (0 when PARITY = 0)
frame_err  output  1  a stop bit was sampled low for the word in data
overrun  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  receiver is inside a frame (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous):
  - data = 0; valid, parity_err, frame_err, overrun, busy = 0.
  - 2-FF synchronizer stages and previous-sample register = 1.
  - State = IDLE; bit counter and cycle counter = 0.
- Input path:
  - rx passes through a 2-FF synchronizer; all decisions use the synchronized value rxs.
  - Falling-edge detect compares rxs with its registered previous value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a rxs 1->0 edge, go to START and clear the cycle counter.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample.
    - rxs = 1: glitch; return to IDLE with no output.
    - rxs = 0: go to DATA, clear the cycle counter and bit index.
  - DATA: sample every CLKS_PER_BIT cycles (counter wraps at CLKS_PER_BIT - 1).
    - Shift the sample into the MSB of the shift register, LSB-first on the line.
    - After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample at mid-bit.
    - Odd mode: error when (XOR of data bits XOR sample) = 0.
    - Even mode: error when that XOR = 1.
  - STOP: STOP_BITS samples at mid-bit; any sample of 0 sets the frame error.
    - After the last stop sample, deliver the frame and return to IDLE in the same cycle.
    - Returning from mid-stop lets a back-to-back start edge be caught.
- Delivery, in the cycle after the last stop sample:
  - If !valid, or valid && ready in that same cycle: load data, parity_err and frame_err; valid = 1.
  - Else: drop the new frame, keep the old word and flags, pulse overrun high for exactly 1 cycle.
- Handshake:
  - valid clears in the cycle after valid && ready unless a new frame loads simultaneously; simultaneous load keeps valid = 1 with the new data.
  - data and error flags are stable while valid = 1 and not accepted.
- Error frames are delivered (not dropped), with their flags set.
- Line held low (break): seen as a frame with frame_err = 1 and data = 0. No new frame starts until rxs returns high and falls again.
- Latency: valid rises 2 (sync) + 1 cycles after the mid-point of the last stop bit on the raw rx.
- Reset mid-frame: immediate abort to IDLE; the partial word is discarded.
- Counter width: $clog2(CLKS_PER_BIT).

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 with ready=1 -> one-cycle valid, data=0xA5, parity_err=0, frame_err=0, busy high for the duration of the frame.
- PARITY=2 (even), send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first word parity_err=0, second word parity_err=1; data=0x07 both times.
- Stop bit forced low on 0x3C -> data=0x3C, frame_err=1, receiver accepts the next frame 0x11 cleanly.
- ready=0, send 0x12 then 0x34 back-to-back -> data stays 0x12, overrun pulses once at the end of 0x34; assert ready -> valid drops next cycle.
- rx low pulse of 5 cycles (< half bit) while idle -> no valid, busy returns to 0 at the mid-start check; the following 0x5A frame is received correctly.
- DATA_BITS=7, STOP_BITS=2, send 0x7F; assert rst low mid-frame, then resend -> first frame produces no output and all outputs read 0; resent frame gives data=0x7F.
